mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WORD_LENGTH, 16, memory word width in bits.
REQ-002 Parameter ADDRESS_SPACE, 12, memory address width in bits.
REQ-003 Ports shall be: clk  in  1  single clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 req_valid  in  1  pipeline request present.
REQ-006 req_op  in  3  operation: 0 NOP, 1 LDD, 2 STD, 3 PUSH, 4 POP, 5 CALL, 6 RET, 7 reserved.
REQ-007 req_addr  in  ADDRESS_SPACE  effective address for LDD/STD.
REQ-008 req_wdata  in  2*WORD_LENGTH  store data; [15:0] for STD/PUSH, full 32 bits for CALL.
REQ-009 req_ready  out  1  high only in IDLE.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  2*WORD_LENGTH  read result.
REQ-012 stall  out  1  high whenever state is not IDLE.
REQ-013 sp  out  ADDRESS_SPACE  current stack pointer.
REQ-014 MAR  out  ADDRESS_SPACE  memory address; MDR_in  out  WORD_LENGTH  memory write data.
REQ-015 MDR_out  in  WORD_LENGTH  memory read data, valid one cycle after a read access; mem  out  1  access enable; rw  out  1  1=read, 0=write.

Function
REQ-016 Request accepted on a rising edge with req_valid && req_ready; op, address, data and SP-derived addresses latched at accept.
REQ-017 FSM states IDLE, A1, R1, A2, R2, DONE; DONE always returns to IDLE next cycle.
REQ-018 Write-type sequence: STD/PUSH IDLE->A1->DONE; CALL IDLE->A1->A2->DONE.
REQ-019 Read-type sequence: LDD/POP IDLE->A1->R1->DONE; RET IDLE->A1->R1->A2->R2->DONE.
REQ-020 NOP and op 7 accepted, IDLE->DONE, no memory access, resp_rdata=0.
REQ-021 mem=1 only in A1/A2; rw=1 for read ops; in all other states mem=0, rw=0, MAR=0, MDR_in=0.
REQ-022 Addresses: LDD/STD at req_addr; PUSH mem[SP]=wdata[15:0]; POP reads mem[SP+1].
REQ-023 Addresses: CALL A1 writes mem[SP]=wdata[31:16], A2 writes mem[SP-1]=wdata[15:0]; RET A1 reads mem[SP+1] (low), A2 reads mem[SP+2] (high).
REQ-024 MDR_out captured at end of R1 (low half) and R2 (high half); 16-bit reads zero-extended into resp_rdata.
REQ-025 SP update committed on entry to DONE: PUSH -1, POP +1, CALL -2, RET +2; all address/SP arithmetic modulo 2^ADDRESS_SPACE (0xFFF+1=0x000, 0x000-1=0xFFF).
REQ-026 resp_rdata updated only on DONE entry for read ops, otherwise held; resp_valid high exactly in DONE.
REQ-027 Latency accept-edge to resp_valid: STD/PUSH 2, LDD/POP 3, CALL 3, RET 5, NOP 1 cycles.
REQ-028 req_valid ignored while stall=1; back-to-back requests spaced by at least one IDLE cycle.

Reset
REQ-029 reset asserted: state=IDLE, sp=0xFFF, resp_valid=0, resp_rdata=0, mem=0, rw=0, MAR=0, MDR_in=0, stall=0, req_ready=1.
REQ-030 Reset mid-operation aborts immediately: no further memory access, no SP commit, no resp_valid.

Structure
REQ-031 Shared package mem_pkg holds op encodings, FSM state enum, SP_RESET=0xFFF, WORD_LENGTH/ADDRESS_SPACE defaults.
REQ-032 One sub-module sp_reg: SP register with async reset, +1/-1/+2/-2 commit, wrap-around.

Verification (bench uses 1-cycle-latency behavioral DataMem)
REQ-033 After reset: sp=0xFFF, mem=0, req_ready=1, resp_valid=0, MAR=0.
REQ-034 STD addr 10 data 100, then LDD addr 10 -> one write cycle at MAR=10, resp_rdata=0x0064 three cycles after LDD accept.
REQ-035 CALL wdata 0x1234ABCD -> mem[0xFFF]=0x1234, mem[0xFFE]=0xABCD, sp=0xFFD; then RET -> resp_rdata=0x1234ABCD, sp=0xFFF, resp_valid 5 cycles after accept.
REQ-036 PUSH 300 then POP -> resp_rdata=300, sp back to 0xFFF; POP at sp=0xFFF reads address 0x000, sp=0x000.
REQ-037 Op 7 -> resp_valid next cycle, mem never asserted, resp_rdata=0; req_valid held high during a RET -> only one request accepted.
REQ-038 Reset asserted during RET state A2 -> mem=0 immediately, sp=0xFFF, no resp_valid.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: op codes, FSM states
// and default widths.
package mem_pkg;

  localparam int unsigned WORD_LENGTH_DEF   = 16;
  localparam int unsigned ADDRESS_SPACE_DEF = 12;
  localparam int unsigned SP_RESET          = 32'h0000_0FFF;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LDD  = 3'd1,
    OP_STD  = 3'd2,
    OP_PUSH = 3'd3,
    OP_POP  = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_RSV  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A1   = 3'd1,
    S_R1   = 3'd2,
    S_A2   = 3'd3,
    S_R2   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  function automatic logic is_read(input op_e op);
    return (op == OP_LDD) || (op == OP_POP) || (op == OP_RET);
  endfunction

  // NOP and the reserved code complete without touching memory
  function automatic logic is_mem_op(input op_e op);
    return (op != OP_NOP) && (op != OP_RSV);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response and data-memory signals of the access controller.
interface mem_access_ctrl_if #(
  parameter int unsigned WORD_LENGTH   = mem_pkg::WORD_LENGTH_DEF,
  parameter int unsigned ADDRESS_SPACE = mem_pkg::ADDRESS_SPACE_DEF
) ();

  logic                       req_valid;
  logic [2:0]                 req_op;
  logic [ADDRESS_SPACE-1:0]   req_addr;
  logic [2*WORD_LENGTH-1:0]   req_wdata;
  logic                       req_ready;
  logic                       resp_valid;
  logic [2*WORD_LENGTH-1:0]   resp_rdata;
  logic                       stall;
  logic [ADDRESS_SPACE-1:0]   sp;
  logic [ADDRESS_SPACE-1:0]   MAR;
  logic [WORD_LENGTH-1:0]     MDR_in;
  logic [WORD_LENGTH-1:0]     MDR_out;
  logic                       mem;
  logic                       rw;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, MDR_out,
    output req_ready, resp_valid, resp_rdata, stall, sp, MAR, MDR_in, mem, rw
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, MDR_out,
    input  req_ready, resp_valid, resp_rdata, stall, sp, MAR, MDR_in, mem, rw
  );

endinterface

// File: rtl/mem_access_ctrl_sp_reg.sv
// Stack pointer register; commits the stack-op adjustment, wrapping modulo 2^AW.
module sp_reg
  import mem_pkg::*;
#(
  parameter int unsigned AW = ADDRESS_SPACE_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          commit,
  input  op_e           op,
  output logic [AW-1:0] sp
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= AW'(SP_RESET);
    end else if (commit) begin
      case (op)
        OP_PUSH: sp <= sp - AW'(1);
        OP_POP:  sp <= sp + AW'(1);
        OP_CALL: sp <= sp - AW'(2);
        OP_RET:  sp <= sp + AW'(2);
        default: sp <= sp;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences LDD/STD/stack operations onto a single-port, 1-cycle-latency data
// memory, one 16-bit access per A-state.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned WORD_LENGTH   = WORD_LENGTH_DEF,
  parameter int unsigned ADDRESS_SPACE = ADDRESS_SPACE_DEF
) (
  input logic               clk,
  input logic               reset,
  mem_access_ctrl_if.slave  bus
);

  localparam int unsigned WL = WORD_LENGTH;
  localparam int unsigned DW = 2 * WORD_LENGTH;
  localparam int unsigned AW = ADDRESS_SPACE;

  state_e        state;
  op_e           op_q;
  logic [AW-1:0] a2_q;
  logic [WL-1:0] wd_lo_q;
  logic [WL-1:0] lo_q;
  logic [AW-1:0] sp_q;

  op_e           req_op_c;
  logic [AW-1:0] a1_c;
  logic [AW-1:0] a2_c;
  logic          commit_c;

  assign req_op_c = op_e'(bus.req_op);
  assign bus.sp   = sp_q;

  // First/second access addresses, derived from the SP seen at accept
  always_comb begin
    a1_c = bus.req_addr;
    a2_c = '0;
    case (req_op_c)
      OP_PUSH: a1_c = sp_q;
      OP_POP:  a1_c = sp_q + AW'(1);
      OP_CALL: begin a1_c = sp_q;          a2_c = sp_q - AW'(1); end
      OP_RET:  begin a1_c = sp_q + AW'(1); a2_c = sp_q + AW'(2); end
      default: ;
    endcase
  end

  // High on the edge that enters DONE from a memory state
  assign commit_c = ((state == S_A1) && ((op_q == OP_STD) || (op_q == OP_PUSH))) ||
                    ((state == S_R1) && (op_q != OP_RET)) ||
                    ((state == S_A2) && (op_q == OP_CALL)) ||
                    (state == S_R2);

  sp_reg #(.AW(AW)) u_sp_reg (
    .clk    (clk),
    .reset  (reset),
    .commit (commit_c),
    .op     (op_q),
    .sp     (sp_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      op_q           <= OP_NOP;
      a2_q           <= '0;
      wd_lo_q        <= '0;
      lo_q           <= '0;
      bus.req_ready  <= 1'b1;
      bus.stall      <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem        <= 1'b0;
      bus.rw         <= 1'b0;
      bus.MAR        <= '0;
      bus.MDR_in     <= '0;
    end else begin
      bus.mem        <= 1'b0;
      bus.rw         <= 1'b0;
      bus.MAR        <= '0;
      bus.MDR_in     <= '0;
      bus.resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            op_q          <= req_op_c;
            a2_q          <= a2_c;
            wd_lo_q       <= bus.req_wdata[WL-1:0];
            bus.req_ready <= 1'b0;
            bus.stall     <= 1'b1;
            if (is_mem_op(req_op_c)) begin
              state      <= S_A1;
              bus.mem    <= 1'b1;
              bus.rw     <= is_read(req_op_c);
              bus.MAR    <= a1_c;
              // CALL stores the high half first, at the old SP
              bus.MDR_in <= (req_op_c == OP_CALL) ? bus.req_wdata[DW-1:WL]
                                                  : bus.req_wdata[WL-1:0];
            end else begin
              state          <= S_DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= '0;
            end
          end
        end
        S_A1: begin
          if (op_q == OP_CALL) begin
            state      <= S_A2;
            bus.mem    <= 1'b1;
            bus.MAR    <= a2_q;
            bus.MDR_in <= wd_lo_q;
          end else if (is_read(op_q)) begin
            state <= S_R1;
          end else begin
            state          <= S_DONE;
            bus.resp_valid <= 1'b1;
          end
        end
        S_R1: begin
          if (op_q == OP_RET) begin
            lo_q    <= bus.MDR_out;
            state   <= S_A2;
            bus.mem <= 1'b1;
            bus.rw  <= 1'b1;
            bus.MAR <= a2_q;
          end else begin
            state          <= S_DONE;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= {{WL{1'b0}}, bus.MDR_out};
          end
        end
        S_A2: begin
          if (op_q == OP_CALL) begin
            state          <= S_DONE;
            bus.resp_valid <= 1'b1;
          end else begin
            state <= S_R2;
          end
        end
        S_R2: begin
          state          <= S_DONE;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= {bus.MDR_out, lo_q};
        end
        S_DONE: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
          bus.stall     <= 1'b0;
        end
        default: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
          bus.stall     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed vector table, hand-written corner
// sequences and random ops against a word-level stack/memory model.
module tb_mem_access_ctrl;

  localparam int unsigned WL = 16;
  localparam int unsigned AW = 12;
  localparam int          MSZ = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_access_ctrl_if #(.WORD_LENGTH(WL), .ADDRESS_SPACE(AW)) bus ();

  mem_access_ctrl #(.WORD_LENGTH(WL), .ADDRESS_SPACE(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural data memory with one cycle of read latency
  logic [15:0] data_mem [0:MSZ-1];
  initial begin
    for (int i = 0; i < MSZ; i++) data_mem[i] = 16'h0000;
    bus.MDR_out <= 16'h0000;
    forever begin
      @(posedge clk);
      if (bus.mem) begin
        if (bus.rw) bus.MDR_out <= data_mem[bus.MAR];
        else        data_mem[bus.MAR] = bus.MDR_in;
      end
    end
  end

  int resp_cnt = 0;
  int mem_cnt  = 0;
  int viol     = 0;

  // Cycle-by-cycle monitors: pulses, access cycles and idle-bus rules
  always @(posedge clk) begin
    if (!reset) begin
      if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
      if (bus.mem)        mem_cnt  <= mem_cnt + 1;
      if ((!bus.mem && (bus.MAR != 0 || bus.MDR_in != 0 || bus.rw)) ||
          (bus.stall == bus.req_ready))
        viol <= viol + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: word memory, stack pointer and last read result
  logic [15:0] ref_mem [0:MSZ-1];
  int          ref_sp;
  logic [31:0] ref_rd;

  task automatic model(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat, output int mc);
    int s;
    s = ref_sp;
    case (op)
      3'd1: begin ref_rd = {16'h0, ref_mem[addr]}; lat = 3; mc = 1; end
      3'd2: begin ref_mem[addr] = wd[15:0]; lat = 2; mc = 1; end
      3'd3: begin ref_mem[s] = wd[15:0]; ref_sp = (s + MSZ - 1) % MSZ; lat = 2; mc = 1; end
      3'd4: begin ref_sp = (s + 1) % MSZ; ref_rd = {16'h0, ref_mem[ref_sp]}; lat = 3; mc = 1; end
      3'd5: begin
        ref_mem[s] = wd[31:16];
        ref_mem[(s + MSZ - 1) % MSZ] = wd[15:0];
        ref_sp = (s + MSZ - 2) % MSZ; lat = 3; mc = 2;
      end
      3'd6: begin
        ref_rd = {ref_mem[(s + 2) % MSZ], ref_mem[(s + 1) % MSZ]};
        ref_sp = (s + 2) % MSZ; lat = 5; mc = 2;
      end
      default: begin ref_rd = 32'h0; lat = 1; mc = 0; end
    endcase
    rd = ref_rd;
  endtask

  // Issue one request; returns cycles from accept edge to resp_valid and access count
  task automatic run_txn(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         input bit hold, output int lat, output logic [31:0] rd, output int mcyc);
    int m0;
    int guard;
    lat = -1;
    rd  = 32'h0;
    @(negedge clk);
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    m0 = mem_cnt;
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = k;
        rd  = bus.resp_rdata;
        break;
      end
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    mcyc = mem_cnt - m0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    logic [11:0] sp;
    int          mc;
  } vec_t;

  vec_t vecs [12];

  task automatic check_reset_state(input string tag);
    check({tag, "_sp"},         32'(bus.sp), 32'h0000_0FFF);
    check({tag, "_mem"},        32'(bus.mem), 32'h0);
    check({tag, "_rw"},         32'(bus.rw), 32'h0);
    check({tag, "_req_ready"},  32'(bus.req_ready), 32'h1);
    check({tag, "_stall"},      32'(bus.stall), 32'h0);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
    check({tag, "_MAR"},        32'(bus.MAR), 32'h0);
    check({tag, "_MDR_in"},     32'(bus.MDR_in), 32'h0);
    check({tag, "_resp_rdata"}, bus.resp_rdata, 32'h0);
  endtask

  initial begin
    int          lat, mlat, mc, mmc, bad, r0, m0;
    logic [31:0] rd, mrd;
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;

    //          op     addr     wdata          rdata         lat sp       mem
    vecs[0]  = '{3'd2, 12'h000, 32'h0000_5A5A, 32'h0000_0000, 2, 12'hFFF, 1};
    vecs[1]  = '{3'd2, 12'h00A, 32'h0000_0064, 32'h0000_0000, 2, 12'hFFF, 1};
    vecs[2]  = '{3'd1, 12'h00A, 32'h0000_0000, 32'h0000_0064, 3, 12'hFFF, 1};
    vecs[3]  = '{3'd5, 12'h000, 32'h1234_ABCD, 32'h0000_0064, 3, 12'hFFD, 2};
    vecs[4]  = '{3'd6, 12'h000, 32'h0000_0000, 32'h1234_ABCD, 5, 12'hFFF, 2};
    vecs[5]  = '{3'd3, 12'h000, 32'h0000_012C, 32'h1234_ABCD, 2, 12'hFFE, 1};
    vecs[6]  = '{3'd4, 12'h000, 32'h0000_0000, 32'h0000_012C, 3, 12'hFFF, 1};
    vecs[7]  = '{3'd4, 12'h000, 32'h0000_0000, 32'h0000_5A5A, 3, 12'h000, 1};
    vecs[8]  = '{3'd3, 12'h000, 32'h0000_BEEF, 32'h0000_5A5A, 2, 12'hFFF, 1};
    vecs[9]  = '{3'd7, 12'h055, 32'hFFFF_FFFF, 32'h0000_0000, 1, 12'hFFF, 0};
    vecs[10] = '{3'd1, 12'h000, 32'h0000_0000, 32'h0000_BEEF, 3, 12'hFFF, 1};
    vecs[11] = '{3'd0, 12'h000, 32'h0000_0000, 32'h0000_0000, 1, 12'hFFF, 0};

    for (int i = 0; i < MSZ; i++) ref_mem[i] = 16'h0000;
    ref_sp = 'hFFF;
    ref_rd = 32'h0;

    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = 12'h000;
    bus.req_wdata = 32'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      model(vecs[i].op, vecs[i].addr, vecs[i].wd, mrd, mlat, mmc);
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].wd, 1'b0, lat, rd, mc);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      check($sformatf("vec%0d_sp", i), 32'(bus.sp), 32'(vecs[i].sp));
      check($sformatf("vec%0d_mem_cycles", i), 32'(mc), 32'(vecs[i].mc));
    end
    check("mem_0x00A", 32'(data_mem[12'h00A]), 32'h0064);
    check("mem_0xFFE", 32'(data_mem[12'hFFE]), 32'hABCD);
    check("mem_0xFFF", 32'(data_mem[12'hFFF]), 32'h012C);
    check("mem_0x000", 32'(data_mem[12'h000]), 32'hBEEF);

    // RET with req_valid held through the stall: exactly one accept
    r0 = resp_cnt;
    model(3'd6, 12'h000, 32'h0, mrd, mlat, mmc);
    run_txn(3'd6, 12'h000, 32'h0, 1'b1, lat, rd, mc);
    repeat (3) @(negedge clk);
    check("hold_ret_latency", 32'(lat), 32'd5);
    check("hold_ret_rdata", rd, 32'h0000_BEEF);
    check("hold_ret_sp", 32'(bus.sp), 32'h0000_0001);
    check("hold_resp_pulses", 32'(resp_cnt - r0), 32'd1);
    check("hold_mem_cycles", 32'(mc), 32'd2);
    check("hold_ready_after", 32'(bus.req_ready), 32'h1);

    // Random ops against the model
    for (int n = 0; n < 60; n++) begin
      op   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
      wd   = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model(op, addr, wd, mrd, mlat, mmc);
      run_txn(op, addr, wd, 1'b0, lat, rd, mc);
      check($sformatf("rnd%0d_op%0d_latency", n, op), 32'(lat), 32'(mlat));
      check($sformatf("rnd%0d_op%0d_rdata", n, op), rd, mrd);
      check($sformatf("rnd%0d_op%0d_sp", n, op), 32'(bus.sp), 32'(ref_sp));
      check($sformatf("rnd%0d_op%0d_mem_cycles", n, op), 32'(mc), 32'(mmc));
    end
    bad = 0;
    for (int i = 0; i < MSZ; i++) if (data_mem[i] !== ref_mem[i]) bad++;
    check("mem_image_mismatches", 32'(bad), 32'd0);

    // Reset between operations, then abort a RET while it sits in A2
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset2");
    reset = 1'b0;
    ref_sp = 'hFFF;
    for (int i = 0; i < 2; i++) begin
      model(3'd3, 12'h000, 32'h0000_0100 + 32'(i), mrd, mlat, mmc);
      run_txn(3'd3, 12'h000, 32'h0000_0100 + 32'(i), 1'b0, lat, rd, mc);
    end
    check("pre_abort_sp", 32'(bus.sp), 32'h0000_0FFD);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd6;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_a2_mem", 32'(bus.mem), 32'h1);
    check("abort_in_a2_MAR", 32'(bus.MAR), 32'h0000_0FFF);
    r0 = resp_cnt;
    m0 = mem_cnt;
    #1 reset = 1'b1;
    #1;
    check("abort_mem_now", 32'(bus.mem), 32'h0);
    check("abort_sp_now", 32'(bus.sp), 32'h0000_0FFF);
    check("abort_resp_valid_now", 32'(bus.resp_valid), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_resp", 32'(resp_cnt - r0), 32'd0);
    check("abort_no_access", 32'(mem_cnt - m0), 32'd0);
    check("abort_sp_after", 32'(bus.sp), 32'h0000_0FFF);
    check("abort_idle_after", 32'(bus.req_ready), 32'h1);

    check("bus_rule_violations", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
